branch_redirect_unit: RTL

- Parametrised successor to the pipeline's control-hazard redirect logic.
- Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, so IF predicts the next PC instead of always fetching PC+1.
- Compares each resolved control instruction's predicted successor with its real successor, then raises a redirect and trains the table.
- Sits between IF (lookup) and the resolve stage (ID/EX, update + redirect).

---
 rtl/branch_redirect_unit_pkg.sv | 21 ++
 rtl/branch_redirect_unit_btb_table.sv | 89 ++++++++
 rtl/branch_redirect_unit.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/branch_redirect_unit_pkg.sv
// Shared definitions for the branch redirect unit: 2-bit counter states and
// saturating counter helpers.
// Optional feature macro: BPU_PERF_CNT_EN (default off). When defined, the top
// module gains perf_ctrl / perf_mispred event counters.
package branch_redirect_unit_pkg;

    // Counter states: strongly/weakly not-taken, weakly/strongly taken
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    function automatic logic [1:0] sat_inc(input logic [1:0] cnt);
        return (cnt == ST) ? ST : cnt + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] cnt);
        return (cnt == SNT) ? SNT : cnt - 2'b01;
    endfunction

endpackage

// File: rtl/branch_redirect_unit_btb_table.sv
// Direct-mapped BTB storage. Holds valid/tag/target/counter per entry.
// Two combinational read ports (IF lookup, resolve-stage lookup) and a single
// full-entry write port that takes effect at the next clock edge.
module btb_table
    import branch_redirect_unit_pkg::*;
#(
    parameter int         WORD_W   = 16,
    parameter int         ENTRIES  = 16,
    parameter int         IDX_W    = $clog2(ENTRIES),
    parameter logic [1:0] CNT_INIT = WNT
) (
    input  logic                    clk,
    input  logic                    reset,
    // IF lookup port
    input  logic [IDX_W-1:0]        lk_idx,
    output logic                    lk_valid,
    output logic [WORD_W-IDX_W-1:0] lk_tag,
    output logic [WORD_W-1:0]       lk_target,
    output logic                    lk_cnt_hi,
    // Resolve-stage lookup port
    input  logic [IDX_W-1:0]        rs_idx,
    output logic                    rs_valid,
    output logic [WORD_W-IDX_W-1:0] rs_tag,
    output logic [WORD_W-1:0]       rs_target,
    output logic [1:0]              rs_cnt,
    // Write port
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_idx,
    input  logic                    wr_valid,
    input  logic [WORD_W-IDX_W-1:0] wr_tag,
    input  logic [WORD_W-1:0]       wr_target,
    input  logic [1:0]              wr_cnt
);

    localparam int TAG_W = WORD_W - IDX_W;

    logic              valid_q  [ENTRIES];
    logic              valid_d  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [TAG_W-1:0]  tag_d    [ENTRIES];
    logic [WORD_W-1:0] target_q [ENTRIES];
    logic [WORD_W-1:0] target_d [ENTRIES];
    logic [1:0]        cnt_q    [ENTRIES];
    logic [1:0]        cnt_d    [ENTRIES];

    // Read ports return the current (pre-write) contents
    always_comb begin
        lk_valid  = valid_q[lk_idx];
        lk_tag    = tag_q[lk_idx];
        lk_target = target_q[lk_idx];
        lk_cnt_hi = cnt_q[lk_idx][1];
        rs_valid  = valid_q[rs_idx];
        rs_tag    = tag_q[rs_idx];
        rs_target = target_q[rs_idx];
        rs_cnt    = cnt_q[rs_idx];
    end

    // Next-state: hold everything, overwrite the addressed entry on a write
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        if (wr_en) begin
            valid_d[wr_idx]  = wr_valid;
            tag_d[wr_idx]    = wr_tag;
            target_d[wr_idx] = wr_target;
            cnt_d[wr_idx]    = wr_cnt;
        end
    end

    // Storage registers; reset invalidates all entries and re-seeds counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= CNT_INIT;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/branch_redirect_unit.sv
// Branch redirect unit: BTB-based next-PC prediction for IF, misprediction
// detection and table training for the resolve stage.
// Optional feature macro: BPU_PERF_CNT_EN (default off) adds perf_ctrl and
// perf_mispred 32-bit event counters.
module branch_redirect_unit
    import branch_redirect_unit_pkg::*;
#(
    parameter int         WORD_W   = 16,
    parameter int         ENTRIES  = 16,
    parameter int         IDX_W    = $clog2(ENTRIES),
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] if_pc,
    output logic [WORD_W-1:0] pred_pc,
    output logic              pred_taken,
    input  logic              res_valid,
    input  logic              res_is_ctrl,
    input  logic [WORD_W-1:0] res_pc,
    input  logic [WORD_W-1:0] res_pred_next,
    input  logic [WORD_W-1:0] res_actual_next,
    output logic              redirect,
    output logic [WORD_W-1:0] redirect_pc
`ifdef BPU_PERF_CNT_EN
    ,
    output logic [31:0]       perf_ctrl,
    output logic [31:0]       perf_mispred
`endif
);

    localparam int TAG_W = WORD_W - IDX_W;
    localparam logic [WORD_W-1:0] PC_STEP = {{(WORD_W-1){1'b0}}, 1'b1};

    logic              lk_valid;
    logic [TAG_W-1:0]  lk_tag;
    logic [WORD_W-1:0] lk_target;
    logic              lk_cnt_hi;
    logic              rs_valid;
    logic [TAG_W-1:0]  rs_tag;
    logic [WORD_W-1:0] rs_target;
    logic [1:0]        rs_cnt;

    logic              wr_en;
    logic              wr_valid;
    logic [TAG_W-1:0]  wr_tag;
    logic [WORD_W-1:0] wr_target;
    logic [1:0]        wr_cnt;

    logic              res_hit;
    logic              res_taken;

    btb_table #(
        .WORD_W   (WORD_W),
        .ENTRIES  (ENTRIES),
        .IDX_W    (IDX_W),
        .CNT_INIT (CNT_INIT)
    ) u_btb (
        .clk       (clk),
        .reset     (reset),
        .lk_idx    (if_pc[IDX_W-1:0]),
        .lk_valid  (lk_valid),
        .lk_tag    (lk_tag),
        .lk_target (lk_target),
        .lk_cnt_hi (lk_cnt_hi),
        .rs_idx    (res_pc[IDX_W-1:0]),
        .rs_valid  (rs_valid),
        .rs_tag    (rs_tag),
        .rs_target (rs_target),
        .rs_cnt    (rs_cnt),
        .wr_en     (wr_en),
        .wr_idx    (res_pc[IDX_W-1:0]),
        .wr_valid  (wr_valid),
        .wr_tag    (wr_tag),
        .wr_target (wr_target),
        .wr_cnt    (wr_cnt)
    );

    // IF prediction: take the stored target only on a hit with a taken-leaning counter
    always_comb begin
        pred_taken = lk_valid && (lk_tag == if_pc[WORD_W-1:IDX_W]) && lk_cnt_hi;
        pred_pc    = pred_taken ? lk_target : if_pc + PC_STEP;
    end

    // Redirect whenever the fetched successor differs from the real one, branch or not
    always_comb begin
        redirect    = res_valid && (res_pred_next != res_actual_next);
        redirect_pc = redirect ? res_actual_next : '0;
    end

    // Training decision: retarget/strengthen, allocate, weaken, or kill a stale alias
    always_comb begin
        res_hit   = rs_valid && (rs_tag == res_pc[WORD_W-1:IDX_W]);
        res_taken = (res_actual_next != res_pc + PC_STEP);
        wr_en     = 1'b0;
        wr_valid  = rs_valid;
        wr_tag    = rs_tag;
        wr_target = rs_target;
        wr_cnt    = rs_cnt;
        if (res_valid) begin
            if (res_is_ctrl) begin
                if (res_taken) begin
                    wr_en     = 1'b1;
                    wr_target = res_actual_next;
                    if (res_hit) begin
                        wr_cnt = sat_inc(rs_cnt);
                    end else begin
                        wr_valid = 1'b1;
                        wr_tag   = res_pc[WORD_W-1:IDX_W];
                        wr_cnt   = WT;
                    end
                end else if (res_hit) begin
                    wr_en  = 1'b1;
                    wr_cnt = sat_dec(rs_cnt);
                end
            end else if (res_hit) begin
                wr_en    = 1'b1;
                wr_valid = 1'b0;
            end
        end
    end

`ifdef BPU_PERF_CNT_EN
    logic [31:0] perf_ctrl_q;
    logic [31:0] perf_ctrl_d;
    logic [31:0] perf_mispred_q;
    logic [31:0] perf_mispred_d;

    // Event counters: resolved control instructions and raised redirects
    always_comb begin
        perf_ctrl_d    = perf_ctrl_q + {31'd0, (res_valid && res_is_ctrl)};
        perf_mispred_d = perf_mispred_q + {31'd0, redirect};
    end

    // Counter registers, wrapping naturally at 2^32
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_ctrl_q    <= '0;
            perf_mispred_q <= '0;
        end else begin
            perf_ctrl_q    <= perf_ctrl_d;
            perf_mispred_q <= perf_mispred_d;
        end
    end

    assign perf_ctrl    = perf_ctrl_q;
    assign perf_mispred = perf_mispred_q;
`endif

endmodule
